dlfloat_operand_loader: RTL and testbench

- Upstream feeder for the DLFloat16 MAC datapath.
- Assembles a byte-serial input stream from the 8-bit pins into operand pairs (a, b), then presents each pair to the MAC with a valid/ready handshake.
- Frame order: a_lo, a_hi, b_lo, b_hi.
- Also provides a one-entry output holding slot with back-pressure, a mid-frame timeout abort, operand classification flags (NaN 16'hFFFF / zero) and a count of issued pairs.

---
 rtl/dlfloat_operand_loader_if.sv | 34 +++
 rtl/dlfloat_operand_loader.sv | 168 ++++++++++++++++
 tb/tb_dlfloat_operand_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dlfloat_operand_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dlfloat_operand_loader_if : byte-in / operand-pair-out bus bundle  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface dlfloat_operand_loader_if #(
   parameter int CNT_W = 8
);
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             mac_ready;
   logic [15:0]      op_a;
   logic [15:0]      op_b;
   logic             op_valid;
   logic             op_nan;
   logic             op_zero;
   logic             frame_err;
   logic [CNT_W-1:0] pair_count;

   // master is the loader itself; slave is the byte source / MAC side
   modport master (
      input  byte_in, byte_valid, mac_ready,
      output byte_ready, op_a, op_b, op_valid, op_nan, op_zero,
             frame_err, pair_count
   );

   modport slave (
      output byte_in, byte_valid, mac_ready,
      input  byte_ready, op_a, op_b, op_valid, op_nan, op_zero,
             frame_err, pair_count
   );
endinterface
`default_nettype wire

// File: rtl/dlfloat_operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dlfloat_operand_loader : assembles byte stream into DLFloat16      |
// | operand pairs with a one-entry holding slot and mid-frame timeout. |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module dlfloat_operand_loader #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8,
   parameter int CNT_W          = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dlfloat_operand_loader_if.master  bus
);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t             state_q, state_d;
   logic [1:0]         byte_idx_q, byte_idx_d;
   logic [15:0]        asm_a_q, asm_a_d;
   logic [15:0]        asm_b_q, asm_b_d;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic [15:0]        op_a_q, op_a_d;
   logic [15:0]        op_b_q, op_b_d;
   logic               op_valid_q, op_valid_d;
   logic               op_nan_q, op_nan_d;
   logic               op_zero_q, op_zero_d;
   logic               frame_err_q, frame_err_d;
   logic [CNT_W-1:0]   pair_count_q, pair_count_d;
   logic               rdy_en_q;

   logic               accept;
   logic               consume;
   logic               load;
   logic [15:0]        ld_a;
   logic [15:0]        ld_b;

   // Keeps byte_ready low while in reset and releases it on the first edge after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en_q <= 1'b0;
      else        rdy_en_q <= 1'b1;
   end

   assign bus.byte_ready = rdy_en_q & (state_q == COLLECT);
   assign accept         = bus.byte_valid & bus.byte_ready;
   assign consume        = op_valid_q & bus.mac_ready;

   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      asm_a_d      = asm_a_q;
      asm_b_d      = asm_b_q;
      to_cnt_d     = to_cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_valid_d   = op_valid_q;
      op_nan_d     = op_nan_q;
      op_zero_d    = op_zero_q;
      frame_err_d  = 1'b0;
      pair_count_d = pair_count_q;
      load         = 1'b0;
      ld_a         = asm_a_q;
      ld_b         = asm_b_q;

      if (consume) begin
         op_valid_d   = 1'b0;
         pair_count_d = pair_count_q + 1'b1;
      end

      case (state_q)
         COLLECT: begin
            if (accept) begin
               to_cnt_d   = '0;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: asm_a_d[7:0]  = bus.byte_in;
                  2'd1: asm_a_d[15:8] = bus.byte_in;
                  2'd2: asm_b_d[7:0]  = bus.byte_in;
                  default: begin
                     asm_b_d[15:8] = bus.byte_in;
                     // Bypass the last byte so a free slot loads without a bubble
                     if (!op_valid_q || consume) begin
                        load = 1'b1;
                        ld_b = {bus.byte_in, asm_b_q[7:0]};
                     end else begin
                        state_d = FULL;
                     end
                  end
               endcase
            end else if (byte_idx_q == 2'd0) begin
               to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
               byte_idx_d  = 2'd0;
               to_cnt_d    = '0;
               asm_a_d     = '0;
               asm_b_d     = '0;
               frame_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         FULL: begin
            to_cnt_d = '0;
            if (consume) begin
               load       = 1'b1;
               byte_idx_d = 2'd0;
               state_d    = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase

      if (load) begin
         op_a_d     = ld_a;
         op_b_d     = ld_b;
         op_valid_d = 1'b1;
         op_nan_d   = (ld_a == 16'hFFFF) || (ld_b == 16'hFFFF);
         op_zero_d  = ((ld_a == 16'h0000) || (ld_b == 16'h0000)) &&
                      !((ld_a == 16'hFFFF) || (ld_b == 16'hFFFF));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         byte_idx_q   <= 2'd0;
         asm_a_q      <= '0;
         asm_b_q      <= '0;
         to_cnt_q     <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_valid_q   <= 1'b0;
         op_nan_q     <= 1'b0;
         op_zero_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         pair_count_q <= '0;
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         asm_a_q      <= asm_a_d;
         asm_b_q      <= asm_b_d;
         to_cnt_q     <= to_cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_valid_q   <= op_valid_d;
         op_nan_q     <= op_nan_d;
         op_zero_q    <= op_zero_d;
         frame_err_q  <= frame_err_d;
         pair_count_q <= pair_count_d;
      end
   end

   assign bus.op_a       = op_a_q;
   assign bus.op_b       = op_b_q;
   assign bus.op_valid   = op_valid_q;
   assign bus.op_nan     = op_nan_q;
   assign bus.op_zero    = op_zero_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.pair_count = pair_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dlfloat_operand_loader : directed self-checking bench           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dlfloat_operand_loader;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   dlfloat_operand_loader_if #(.CNT_W(8)) dut_if ();

   dlfloat_operand_loader #(
      .TIMEOUT_CYCLES (4),
      .TO_W           (8),
      .CNT_W          (8)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      dut_if.byte_in    = b;
      dut_if.byte_valid = 1'b1;
      tick();
      dut_if.byte_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] b);
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(b[7:0]);
      send_byte(b[15:8]);
   endtask

   task automatic do_reset();
      dut_if.byte_in    = 8'h00;
      dut_if.byte_valid = 1'b0;
      dut_if.mac_ready  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int pulse_at;
      n_tests = 0;
      n_fail  = 0;
      dut_if.byte_in    = 8'h00;
      dut_if.byte_valid = 1'b0;
      dut_if.mac_ready  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_op_valid",   32'(dut_if.op_valid),   32'h0);
      check_eq("rst_byte_ready", 32'(dut_if.byte_ready), 32'h0);
      check_eq("rst_op_a",       32'(dut_if.op_a),       32'h0);
      check_eq("rst_pair_count", 32'(dut_if.pair_count), 32'h0);
      check_eq("rst_frame_err",  32'(dut_if.frame_err),  32'h0);
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_byte_ready", 32'(dut_if.byte_ready), 32'h1);

      // Back-to-back frame with MAC always ready
      dut_if.mac_ready = 1'b1;
      send_frame(16'h3E00, 16'h4000);
      check_eq("t1_op_valid", 32'(dut_if.op_valid), 32'h1);
      check_eq("t1_op_a",     32'(dut_if.op_a),     32'h3E00);
      check_eq("t1_op_b",     32'(dut_if.op_b),     32'h4000);
      check_eq("t1_op_nan",   32'(dut_if.op_nan),   32'h0);
      check_eq("t1_op_zero",  32'(dut_if.op_zero),  32'h0);
      tick();
      check_eq("t1_valid_drop", 32'(dut_if.op_valid),   32'h0);
      check_eq("t1_pair_count", 32'(dut_if.pair_count), 32'h1);

      // Back-pressure into the holding slot
      do_reset();
      send_frame(16'h1234, 16'h5678);
      check_eq("t2_f1_valid", 32'(dut_if.op_valid), 32'h1);
      check_eq("t2_f1_a",     32'(dut_if.op_a),     32'h1234);
      check_eq("t2_f1_b",     32'(dut_if.op_b),     32'h5678);
      send_frame(16'hABCD, 16'h0000);
      check_eq("t2_full_ready", 32'(dut_if.byte_ready), 32'h0);
      check_eq("t2_hold_a",     32'(dut_if.op_a),       32'h1234);
      check_eq("t2_hold_b",     32'(dut_if.op_b),       32'h5678);
      send_byte(8'h99);
      check_eq("t2_ignored_a",  32'(dut_if.op_a),       32'h1234);
      dut_if.mac_ready = 1'b1;
      tick();
      dut_if.mac_ready = 1'b0;
      check_eq("t2_f2_a",     32'(dut_if.op_a),       32'hABCD);
      check_eq("t2_f2_b",     32'(dut_if.op_b),       32'h0000);
      check_eq("t2_f2_zero",  32'(dut_if.op_zero),    32'h1);
      check_eq("t2_f2_nan",   32'(dut_if.op_nan),     32'h0);
      check_eq("t2_f2_valid", 32'(dut_if.op_valid),   32'h1);
      check_eq("t2_ready",    32'(dut_if.byte_ready), 32'h1);
      check_eq("t2_count",    32'(dut_if.pair_count), 32'h1);

      // Consume coincides with 4th byte: no bubble
      do_reset();
      send_frame(16'h0001, 16'h0002);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h04);
      check_eq("t3_pre_valid", 32'(dut_if.op_valid), 32'h1);
      check_eq("t3_pre_a",     32'(dut_if.op_a),     32'h0001);
      dut_if.byte_in    = 8'h00;
      dut_if.byte_valid = 1'b1;
      dut_if.mac_ready  = 1'b1;
      tick();
      dut_if.byte_valid = 1'b0;
      dut_if.mac_ready  = 1'b0;
      check_eq("t3_valid", 32'(dut_if.op_valid),   32'h1);
      check_eq("t3_a",     32'(dut_if.op_a),       32'h0003);
      check_eq("t3_b",     32'(dut_if.op_b),       32'h0004);
      check_eq("t3_count", 32'(dut_if.pair_count), 32'h1);
      dut_if.mac_ready = 1'b1;
      tick();
      dut_if.mac_ready = 1'b0;
      check_eq("t3_drain_valid", 32'(dut_if.op_valid),   32'h0);
      check_eq("t3_drain_count", 32'(dut_if.pair_count), 32'h2);

      // Timeout after two bytes, then a NaN frame
      do_reset();
      dut_if.mac_ready = 1'b1;
      send_byte(8'hAA);
      send_byte(8'hBB);
      pulses   = 0;
      pulse_at = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (dut_if.frame_err === 1'b1) begin
            pulses++;
            pulse_at = i;
         end
      end
      check_eq("t4_err_pulses", 32'(pulses),   32'd1);
      check_eq("t4_err_cycle",  32'(pulse_at), 32'd4);
      check_eq("t4_slot_idle",  32'(dut_if.op_valid), 32'h0);
      send_frame(16'hFFFF, 16'h0001);
      check_eq("t4_valid", 32'(dut_if.op_valid), 32'h1);
      check_eq("t4_a",     32'(dut_if.op_a),     32'hFFFF);
      check_eq("t4_b",     32'(dut_if.op_b),     32'h0001);
      check_eq("t4_nan",   32'(dut_if.op_nan),   32'h1);
      check_eq("t4_zero",  32'(dut_if.op_zero),  32'h0);

      // Byte lands in the cycle the timeout would fire
      do_reset();
      dut_if.mac_ready = 1'b1;
      send_byte(8'h11);
      send_byte(8'h22);
      pulses = 0;
      repeat (3) begin
         tick();
         if (dut_if.frame_err === 1'b1) pulses++;
      end
      send_byte(8'h33);
      if (dut_if.frame_err === 1'b1) pulses++;
      send_byte(8'h44);
      if (dut_if.frame_err === 1'b1) pulses++;
      check_eq("t5_no_err", 32'(pulses),          32'd0);
      check_eq("t5_valid",  32'(dut_if.op_valid), 32'h1);
      check_eq("t5_a",      32'(dut_if.op_a),     32'h2211);
      check_eq("t5_b",      32'(dut_if.op_b),     32'h4433);

      // Asynchronous reset while FULL
      do_reset();
      dut_if.mac_ready = 1'b1;
      send_frame(16'h0102, 16'h0304);
      tick();
      check_eq("t6_pre_count", 32'(dut_if.pair_count), 32'h1);
      dut_if.mac_ready = 1'b0;
      send_frame(16'h1111, 16'h2222);
      send_frame(16'h3333, 16'h4444);
      check_eq("t6_full_ready", 32'(dut_if.byte_ready), 32'h0);
      check_eq("t6_full_valid", 32'(dut_if.op_valid),   32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_valid", 32'(dut_if.op_valid),   32'h0);
      check_eq("t6_async_a",     32'(dut_if.op_a),       32'h0);
      check_eq("t6_async_b",     32'(dut_if.op_b),       32'h0);
      check_eq("t6_async_count", 32'(dut_if.pair_count), 32'h0);
      check_eq("t6_async_err",   32'(dut_if.frame_err),  32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check_eq("t6_rel_ready", 32'(dut_if.byte_ready), 32'h1);
      check_eq("t6_rel_valid", 32'(dut_if.op_valid),   32'h0);
      dut_if.mac_ready = 1'b1;
      send_frame(16'h0201, 16'h0403);
      check_eq("t6_new_a",     32'(dut_if.op_a),       32'h0201);
      check_eq("t6_new_b",     32'(dut_if.op_b),       32'h0403);
      check_eq("t6_new_count", 32'(dut_if.pair_count), 32'h0);
      tick();
      check_eq("t6_count_after", 32'(dut_if.pair_count), 32'h1);
      dut_if.mac_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
